// File: rtl/copro_op_sequencer.sv
// copro_op_sequencer
//   Front-end controller for the LM32 float coprocessor. Takes one custom
//   instruction at a time, latches opcode/operands, starts the shared float
//   datapath, waits the per-op latency, captures the result and returns it
//   with a single-cycle complete pulse. PASS, illegal opcodes and DIV by zero
//   finish without the datapath.
// Ports
//   clk_i, rst_ni       clock (rising edge), async active-low reset
//   user_valid_i        request, held by the CPU until complete is seen
//   user_opcode_i       0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 PASS, 5-7 illegal
//   user_op0_i/op1_i    operands, low W bits used
//   user_result_o       result, zero-extended from W bits, held until next capture
//   user_complete_o     one-cycle result strobe per request
//   err_o               illegal opcode or DIV by zero, held like the result
//   busy_o              high whenever not idle
//   dp_start_o          one-cycle datapath start
//   dp_sel_o/a_o/b_o    latched op select and operands for the datapath
//   dp_result_i         datapath result, valid LAT cycles after dp_start_o
module copro_op_sequencer #(
  parameter int NM      = 23,
  parameter int NE      = 8,
  parameter int LAT_ADD = 2,
  parameter int LAT_MUL = 3,
  parameter int LAT_DIV = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              user_valid_i,
  input  logic [2:0]        user_opcode_i,
  input  logic [31:0]       user_op0_i,
  input  logic [31:0]       user_op1_i,
  output logic [31:0]       user_result_o,
  output logic              user_complete_o,
  output logic              err_o,
  output logic              busy_o,
  output logic              dp_start_o,
  output logic [1:0]        dp_sel_o,
  output logic [NE+NM:0]    dp_a_o,
  output logic [NE+NM:0]    dp_b_o,
  input  logic [NE+NM:0]    dp_result_i
);
  localparam int W       = 1 + NE + NM;
  localparam int LAT_M0  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
  localparam int LAT_MAX = (LAT_M0 > LAT_DIV) ? LAT_M0 : LAT_DIV;
  localparam int CW      = $clog2(LAT_MAX) + 1;

  localparam logic [CW-1:0] C_LAT_ADD = CW'(LAT_ADD - 1);
  localparam logic [CW-1:0] C_LAT_MUL = CW'(LAT_MUL - 1);
  localparam logic [CW-1:0] C_LAT_DIV = CW'(LAT_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_HOLD} state_t;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_sel;
  logic [W-1:0]    r_a, r_b, r_result;
  logic            r_err;
  logic [CW-1:0]   r_cnt;

  logic            w_latch, w_load, w_cap, w_err_nxt, w_div0;
  logic [W-1:0]    w_res_nxt, w_div0_res;
  logic [CW-1:0]   w_lat_m1;

  // Divide by zero ignores the divisor sign; result is a signed infinity.
  assign w_div0     = (user_opcode_i == 3'd3) && (user_op1_i[W-2:0] == '0);
  assign w_div0_res = {user_op0_i[W-1] ^ user_op1_i[W-1], {NE{1'b1}}, {NM{1'b0}}};

  always_comb begin
    w_lat_m1 = C_LAT_ADD;
    case (r_sel)
      2'd2:    w_lat_m1 = C_LAT_MUL;
      2'd3:    w_lat_m1 = C_LAT_DIV;
      default: w_lat_m1 = C_LAT_ADD;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_load      = 1'b0;
    w_cap       = 1'b0;
    w_res_nxt   = r_result;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: if (user_valid_i) begin
        w_latch = 1'b1;
        if (user_opcode_i <= 3'd3) begin
          if (w_div0) begin
            w_cap       = 1'b1;
            w_res_nxt   = w_div0_res;
            w_err_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end else if (user_opcode_i == 3'd4) begin
          w_cap       = 1'b1;
          w_res_nxt   = user_op0_i[W-1:0];
          w_err_nxt   = 1'b0;
          w_state_nxt = S_DONE;
        end else begin
          w_cap       = 1'b1;
          w_res_nxt   = '0;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_ISSUE: begin
        if (!user_valid_i) w_state_nxt = S_IDLE;
        else begin
          w_load      = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      // Abort has priority over capture: a dropped request never completes.
      S_WAIT: begin
        if (!user_valid_i) w_state_nxt = S_IDLE;
        else if (r_cnt == '0) begin
          w_cap       = 1'b1;
          w_res_nxt   = dp_result_i;
          w_err_nxt   = 1'b0;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: w_state_nxt = S_HOLD;
      // Held valid from the finished request must not start a second one.
      S_HOLD: if (!user_valid_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sel    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_latch) begin
        r_sel <= user_opcode_i[1:0];
        r_a   <= user_op0_i[W-1:0];
        r_b   <= user_op1_i[W-1:0];
      end
      if (w_cap) begin
        r_result <= w_res_nxt;
        r_err    <= w_err_nxt;
      end
      if (w_load)                                 r_cnt <= w_lat_m1;
      else if (r_state == S_WAIT && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
    end
  end

  assign user_result_o   = 32'(r_result);
  assign user_complete_o = (r_state == S_DONE);
  assign err_o           = r_err;
  assign busy_o          = (r_state != S_IDLE);
  assign dp_start_o      = (r_state == S_ISSUE);
  assign dp_sel_o        = r_sel;
  assign dp_a_o          = r_a;
  assign dp_b_o          = r_b;
endmodule
